keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Parametrised matrix-keypad scanner: drives one active-low column per scan step and
//  samples active-low rows through a 2-flop synchroniser. Debounces press and release,
//  and emits one key code per press over a valid/ready handshake.
//  Replaces the divided-clock scanner: runs entirely on clk, using an internal scan tick
//  rather than a generated slow clock. Feeds the calculator decoder/operator logic.
// PARAMETERS
//  ROWS       4       number of row inputs (>=1)
//  COLS       4       number of column outputs (>=2)
//  SCAN_DIV   100000  clk cycles per scan tick (>=2); one column step per tick
//  DEBOUNCE   4       consecutive agreeing ticks required for press/release (>=1)
//  FIFO_DEPTH 4       event FIFO depth, power of 2 (used only with KEYPAD_FIFO_EN)
//  localparam KEY_W = $clog2(ROWS*COLS); code = row_index*COLS + col_index
// PORTS
//  clk        in   1      system clock
//  rst        in   1      asynchronous, active-high reset
//  row        in   ROWS   raw keypad rows, active-low, asynchronous to clk
//  col        out  COLS   column drive, one-cold (exactly one bit 0)
//  key_code   out  KEY_W  code of oldest undelivered press
//  key_valid  out  1      key_code holds an undelivered press
//  key_ready  in   1      consumer accepts key_code on clk edge where valid&&ready
//  key_held   out  1      debounced key currently down (HELD/RELEASE states)
//  overrun    out  1      1-cycle pulse: a debounced press was dropped
// BEHAVIOUR
//  Reset (async): col={COLS{1}} with bit0=0; key_code=0; key_valid=0; key_held=0;
//   overrun=0; state=SCAN; tick counter, debounce counter, column index=0; FIFO empty.
//  tick: counter 0..SCAN_DIV-1, tick=1 for one cycle when counter==SCAN_DIV-1, then wraps.
//  rs = ~row after 2-flop sync; all decisions made only on tick cycles.
//  SCAN: if rs!=0 -> capture r=lowest set bit, c=current column, cnt=1; DEBOUNCE==1 ?
//   emit, ->HELD : ->DEB. Column frozen. Else column advances (COLS-1 wraps to 0).
//  DEB: rs[r]=1 -> cnt++; emit and ->HELD when cnt reaches DEBOUNCE.
//   rs[r]=0 -> cnt=0, ->SCAN, column advances.
//  HELD: rs[r]=0 -> cnt=1, ->RELEASE (DEBOUNCE==1: ->SCAN, column advances).
//  RELEASE: rs[r]=0 -> cnt++; at DEBOUNCE ->SCAN, column advances. rs[r]=1 -> ->HELD.
//  Single-key rollover: other keys ignored from DEB through RELEASE; no auto-repeat.
//  Latency: key_valid rises the cycle after the emitting tick (plus sync delay).
//  Handshake: key_code stable while key_valid=1; drops/advances the cycle after
//   valid&&ready. Emit in same cycle as accept: the accept completes and the new
//   event is stored, so no drop.
//  key_held=1 in HELD and RELEASE.
//  Reset mid-operation abandons everything. A key still down after reset is re-debounced
//   and yields exactly one event.
// CONFIGURATION
//  KEYPAD_FIFO_EN undefined: single holding register. Emit while key_valid&&!key_ready
//   -> new event dropped, overrun pulses; held code is unchanged.
//  KEYPAD_FIFO_EN defined: FIFO_DEPTH-entry FIFO; key_code/key_valid show head.
//   Emit when full without a pop -> dropped, overrun pulses. Full with a same-cycle pop
//   -> push succeeds. Events are delivered in press order.
// TESTING (ROWS=COLS=4, SCAN_DIV=4, DEBOUNCE=3 unless noted)
//  1 No key -> col sequence 1110,1101,1011,0111,1110, each held 4 clk; key_valid stays 0.
//  2 Hold row2 low while col[1]=0, key_ready=1 -> one event key_code=9, key_valid rises
//    after 3rd agreeing tick; key_held=1 until 3 release ticks; no repeat.
//  3 Toggle that key every tick (bounce <3 ticks) -> no event, scan resumes.
//  4 Rows 1 and 3 both pressed in col 2 -> key_code=6 (lowest row wins).
//  5 key_ready=0; press codes 5 then 10 -> no FIFO: key_code=5 held, overrun pulses
//    once. FIFO: 5 then 10 delivered in order; 5th press with ready=0 -> overrun.
//  6 Assert rst during DEB with key down -> outputs reset immediately, col=1110.
//    After rst release with key still down -> exactly one event.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: matrix keypad scanner running entirely on clk.
// Drives one active-low column per scan tick and samples the active-low rows through
// a 2-flop synchroniser. Press and release are both debounced. One key code is
// emitted per press and handed over on a valid/ready handshake.
// Optional feature macro: KEYPAD_FIFO_EN. When it is defined, pressed codes queue in a
// FIFO_DEPTH-entry FIFO. Otherwise a single holding register is used.
module keypad_scanner #(
    parameter  int ROWS       = 4,
    parameter  int COLS       = 4,
    parameter  int SCAN_DIV   = 100000,
    parameter  int DEBOUNCE   = 4,
    parameter  int FIFO_DEPTH = 4,
    localparam int KEY_W      = $clog2(ROWS*COLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ROWS-1:0]  row,
    output logic [COLS-1:0]  col,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             key_held,
    output logic             overrun
);
    localparam int R_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int C_W = $clog2(COLS);
    localparam int T_W = $clog2(SCAN_DIV);
    localparam int D_W = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {SCAN, DEB, HELD, RELEASE} state_t;

    logic [ROWS-1:0]  row_s1, row_s2, rs;
    logic [T_W-1:0]   tick_cnt;
    logic             tick;
    state_t           state, state_nxt;
    logic [C_W-1:0]   col_idx;
    logic [R_W-1:0]   key_r, key_r_nxt, low_r, emit_r;
    logic [D_W-1:0]   cnt, cnt_nxt;
    logic             rs_hit, advance, emit, pop, push;
    logic [KEY_W-1:0] emit_code;

    // Two-flop synchroniser for the asynchronous rows; idle rows read high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s1 <= '1;
            row_s2 <= '1;
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
        end
    end

    assign rs   = ~row_s2;
    assign tick = (tick_cnt == T_W'(SCAN_DIV - 1));

    // Scan tick divider: one-cycle tick every SCAN_DIV clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tick_cnt <= '0;
        else     tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end

    // The lowest active row wins when several rows are down at the same time.
    always_comb begin
        low_r = '0;
        for (int i = ROWS - 1; i >= 0; i--)
            if (rs[i]) low_r = R_W'(i);
    end

    assign rs_hit    = rs[key_r];
    assign emit_r    = (state == SCAN) ? low_r : key_r;
    // The column is frozen from capture to release, so col_idx is the key's column.
    assign emit_code = KEY_W'(emit_r) * KEY_W'(COLS) + KEY_W'(col_idx);

    // Next-state and emit decision. This logic only acts on tick cycles.
    always_comb begin
        state_nxt = state;
        key_r_nxt = key_r;
        cnt_nxt   = cnt;
        advance   = 1'b0;
        emit      = 1'b0;
        if (tick) begin
            unique case (state)
                SCAN: begin
                    if (|rs) begin
                        key_r_nxt = low_r;
                        cnt_nxt   = D_W'(1);
                        if (DEBOUNCE == 1) begin
                            emit      = 1'b1;
                            state_nxt = HELD;
                        end else begin
                            state_nxt = DEB;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
                DEB: begin
                    if (rs_hit) begin
                        cnt_nxt = cnt + 1'b1;
                        if ((cnt + 1'b1) == D_W'(DEBOUNCE)) begin
                            emit      = 1'b1;
                            state_nxt = HELD;
                        end
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = SCAN;
                        advance   = 1'b1;
                    end
                end
                HELD: begin
                    if (!rs_hit) begin
                        cnt_nxt = D_W'(1);
                        if (DEBOUNCE == 1) begin
                            state_nxt = SCAN;
                            advance   = 1'b1;
                        end else begin
                            state_nxt = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (!rs_hit) begin
                        cnt_nxt = cnt + 1'b1;
                        if ((cnt + 1'b1) == D_W'(DEBOUNCE)) begin
                            cnt_nxt   = '0;
                            state_nxt = SCAN;
                            advance   = 1'b1;
                        end
                    end else begin
                        state_nxt = HELD;
                    end
                end
                default: state_nxt = SCAN;
            endcase
        end
    end

    // Scanner state, column drive, and the registered key_held output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SCAN;
            key_r    <= '0;
            cnt      <= '0;
            col_idx  <= '0;
            col      <= ~COLS'(1);
            key_held <= 1'b0;
        end else begin
            state    <= state_nxt;
            key_r    <= key_r_nxt;
            cnt      <= cnt_nxt;
            key_held <= (state_nxt == HELD) || (state_nxt == RELEASE);
            if (advance) begin
                col_idx <= (col_idx == C_W'(COLS - 1)) ? '0 : col_idx + 1'b1;
                col     <= {col[COLS-2:0], col[COLS-1]};
            end
        end
    end

    assign pop = key_valid && key_ready;

`ifdef KEYPAD_FIFO_EN
    localparam int A_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int N_W = $clog2(FIFO_DEPTH + 1);

    logic [FIFO_DEPTH-1:0][KEY_W-1:0] mem;
    logic [A_W-1:0]                   wr_ptr, rd_ptr;
    logic [N_W-1:0]                   count;

    assign key_valid = (count != '0);
    assign key_code  = mem[rd_ptr];
    // When the FIFO is full, a pop in the same cycle makes room for the push.
    assign push      = emit && ((count != N_W'(FIFO_DEPTH)) || pop);

    // Event FIFO. The head is presented on key_code/key_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= emit && !push;
            if (push) begin
                mem[wr_ptr] <= emit_code;
                wr_ptr      <= (wr_ptr == A_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= (rd_ptr == A_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + N_W'(push) - N_W'(pop);
        end
    end
`else
    logic unused_depth;
    assign unused_depth = ^FIFO_DEPTH;
    assign push = emit && (!key_valid || pop);

    // Single holding register. While it is occupied and not being accepted, new
    // presses are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= emit && !push;
            if (push) begin
                key_code  <= emit_code;
                key_valid <= 1'b1;
            end else if (pop) begin
                key_valid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: a keypad matrix model drives the DUT. A tick-level behavioural
// reference checks every output on every cycle. Directed scenarios pin the reference
// with literal expectations.
module tb_keypad_scanner;
    localparam int ROWS = 4, COLS = 4, SCAN_DIV = 4, DEBOUNCE = 3, FIFO_DEPTH = 4;
    localparam int KEY_W = $clog2(ROWS*COLS);
`ifdef KEYPAD_FIFO_EN
    localparam int CAP = FIFO_DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [ROWS-1:0] row;
    logic [COLS-1:0] col;
    logic [KEY_W-1:0] key_code;
    logic key_valid, key_ready, key_held, overrun;
    logic [ROWS-1:0][COLS-1:0] pressed;

    int n_chk = 0, n_pass = 0;

    keypad_scanner #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE),
                     .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .row(row), .col(col), .key_code(key_code),
        .key_valid(key_valid), .key_ready(key_ready), .key_held(key_held),
        .overrun(overrun));

    always #5 clk = ~clk;

    // Physical matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        for (int r = 0; r < ROWS; r++) row[r] = ~|(pressed[r] & ~col);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic logic [COLS-1:0] onecold(input int i);
        logic [COLS-1:0] v;
        v = '1;
        v[i] = 1'b0;
        return v;
    endfunction

    // Reference model state: scan position, lock/debounce status, and the event queue.
    int m_tc, m_ci, m_lr, m_lc, m_agree;
    bit m_locked, m_down, m_ovr;
    logic [ROWS-1:0] h1, h2;
    int q[$];
    int acc_codes[$];
    int ovr_cnt = 0;

    function automatic int code_at(input int i);
        return (i < acc_codes.size()) ? acc_codes[i] : -1;
    endfunction

    task automatic m_reset();
        m_tc = 0; m_ci = 0; m_lr = 0; m_lc = 0; m_agree = 0;
        m_locked = 0; m_down = 0; m_ovr = 0;
        h1 = '1; h2 = '1;
        q.delete();
    endtask

    // Advance the reference across one clock edge, using the values seen this cycle.
    task automatic m_step();
        logic [ROWS-1:0] rs;
        bit tick, emit, adv, pop;
        int lo;
        rs = ~h2;
        tick = (m_tc == SCAN_DIV - 1);
        emit = 0; adv = 0;
        if (tick) begin
            if (!m_locked) begin
                if (rs != '0) begin
                    lo = 0;
                    while (!rs[lo]) lo++;
                    m_lr = lo; m_lc = m_ci; m_locked = 1; m_agree = 1;
                    if (m_agree >= DEBOUNCE) begin emit = 1; m_down = 1; m_agree = 0; end
                end else adv = 1;
            end else if (!m_down) begin
                if (rs[m_lr]) begin
                    m_agree++;
                    if (m_agree >= DEBOUNCE) begin emit = 1; m_down = 1; m_agree = 0; end
                end else begin
                    m_locked = 0; m_agree = 0; adv = 1;
                end
            end else begin
                if (!rs[m_lr]) begin
                    m_agree++;
                    if (m_agree >= DEBOUNCE) begin
                        m_locked = 0; m_down = 0; m_agree = 0; adv = 1;
                    end
                end else m_agree = 0;
            end
        end
        pop = (q.size() > 0) && key_ready;
        if (pop) void'(q.pop_front());
        m_ovr = 0;
        if (emit) begin
            if (q.size() < CAP) q.push_back(m_lr*COLS + m_lc);
            else m_ovr = 1;
        end
        m_tc = tick ? 0 : m_tc + 1;
        if (adv) m_ci = (m_ci + 1) % COLS;
        h2 = h1;
        h1 = row;
    endtask

    // Compare the DUT against the reference on every falling edge.
    always @(negedge clk) begin
        if (rst) begin
            m_reset();
            chk("rst_col", int'(col), int'(4'b1110));
            chk("rst_key_valid", int'(key_valid), 0);
            chk("rst_key_code", int'(key_code), 0);
            chk("rst_key_held", int'(key_held), 0);
            chk("rst_overrun", int'(overrun), 0);
        end else begin
            chk("col", int'(col), int'(onecold(m_ci)));
            chk("key_valid", int'(key_valid), int'(q.size() > 0));
            if (q.size() > 0) chk("key_code", int'(key_code), q[0]);
            chk("key_held", int'(key_held), int'(m_locked && m_down));
            chk("overrun", int'(overrun), int'(m_ovr));
            if (key_valid && key_ready) acc_codes.push_back(int'(key_code));
            if (overrun) ovr_cnt++;
            m_step();
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press_release(input int r, input int c, input int hold, input int gap);
        pressed[r][c] = 1'b1;
        cyc(hold);
        pressed = '0;
        cyc(gap);
    endtask

    logic [COLS-1:0] seq [5];
    int rr, cc, dur, gap;

    initial begin
        seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        pressed = '0;
        key_ready = 1'b0;
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;

        // 1: idle scan with each column held for SCAN_DIV clocks.
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            chk("t1_col_seq", int'(col), int'(seq[n/4]));
        end
        chk("t1_no_valid", int'(key_valid), 0);
        cyc(1);

        // 2: single press of row2/col1 gives exactly one code 9.
        key_ready = 1'b1;
        acc_codes.delete();
        pressed[2][1] = 1'b1;
        cyc(80);
        chk("t2_events", acc_codes.size(), 1);
        chk("t2_code", code_at(0), 9);
        chk("t2_held", int'(key_held), 1);
        pressed = '0;
        cyc(40);
        chk("t2_released", int'(key_held), 0);
        chk("t2_no_repeat", acc_codes.size(), 1);

        // 3: bounce shorter than the debounce window yields no event.
        acc_codes.delete();
        for (int k = 0; k < 16; k++) begin
            pressed[2][1] = ~pressed[2][1];
            cyc(SCAN_DIV);
        end
        pressed = '0;
        cyc(40);
        chk("t3_bounce_events", acc_codes.size(), 0);
        chk("t3_held", int'(key_held), 0);

        // 4: two rows down in column 2, so the lowest row wins.
        acc_codes.delete();
        pressed[1][2] = 1'b1;
        pressed[3][2] = 1'b1;
        cyc(80);
        pressed = '0;
        cyc(40);
        chk("t4_events", acc_codes.size(), 1);
        chk("t4_code", code_at(0), 6);

        // 5: consumer stalled, so storage fills and the next press overruns.
        key_ready = 1'b0;
        acc_codes.delete();
        ovr_cnt = 0;
        press_release(1, 1, 60, 40);
        press_release(2, 2, 60, 40);
`ifdef KEYPAD_FIFO_EN
        press_release(3, 3, 60, 40);
        press_release(0, 0, 60, 40);
        press_release(0, 1, 60, 40);
        chk("t5_overrun_once", ovr_cnt, 1);
        chk("t5_head", int'(key_code), 5);
        key_ready = 1'b1;
        cyc(10);
        chk("t5_drained", acc_codes.size(), 4);
        chk("t5_first", code_at(0), 5);
        chk("t5_second", code_at(1), 10);
        chk("t5_fourth", code_at(3), 0);
`else
        chk("t5_overrun_once", ovr_cnt, 1);
        chk("t5_held_code", int'(key_code), 5);
        chk("t5_valid", int'(key_valid), 1);
        key_ready = 1'b1;
        cyc(10);
        chk("t5_drained", acc_codes.size(), 1);
        chk("t5_first", code_at(0), 5);
`endif

        // 6: reset in mid-debounce, then the key that is still down re-debounces once.
        acc_codes.delete();
        pressed[1][0] = 1'b1;
        for (int i = 0; i < 100 && !(m_locked && !m_down); i++) cyc(1);
        chk("t6_reached_deb", int'(m_locked && !m_down), 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_col", int'(col), int'(4'b1110));
        chk("t6_rst_valid", int'(key_valid), 0);
        chk("t6_rst_held", int'(key_held), 0);
        cyc(2);
        rst = 1'b0;
        cyc(80);
        chk("t6_one_event", acc_codes.size(), 1);
        chk("t6_code", code_at(0), 4);
        pressed = '0;
        cyc(40);

        // Random presses, bounces, ghost second keys, ready patterns, and one reset.
        for (int it = 0; it < 150; it++) begin
            rr  = $urandom_range(0, ROWS-1);
            cc  = $urandom_range(0, COLS-1);
            dur = $urandom_range(1, 60);
            gap = $urandom_range(1, 50);
            pressed = '0;
            pressed[rr][cc] = 1'b1;
            if ($urandom_range(0, 3) == 0)
                pressed[$urandom_range(0, ROWS-1)][$urandom_range(0, COLS-1)] = 1'b1;
            for (int k = 0; k < dur; k++) begin
                key_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 15) == 0) pressed[rr][cc] = ~pressed[rr][cc];
                cyc(1);
            end
            pressed = '0;
            for (int k = 0; k < gap; k++) begin
                key_ready = ($urandom_range(0, 3) != 0);
                cyc(1);
            end
            if (it == 75) begin
                rst = 1'b1;
                cyc(2);
                rst = 1'b0;
            end
        end

        key_ready = 1'b1;
        cyc(20);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
